dma_controller: RTL and testbench
=================================

Name: dma_controller

Overview:
- Memory-mapped block-copy engine attached to the io2 port of the single-cycle MIPS core.
- On the io2 bus it is the responder: the CPU issues io2_write/io2_read strobes to program it and poll it.
- On the data-memory bus it is the initiator: it copies LEN words from SRC to DST.
- While it owns the data-memory bus it raises hal, which stalls the CPU and steers dataMemory inputs to this block.

Parameters:
- ADDR_W, 32, width of memory addresses and the SRC/DST pointers.
- DATA_W, 32, data word width.
- LEN_W, 16, width of the transfer-length register; LEN holds 0..2^LEN_W-1 words.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- io_addr  in  2  register select (word offset within io2 space).
- io_wdata  in  DATA_W  CPU write data.
- io_write  in  1  io2 write strobe; register updates at the clock edge.
- io_read  in  1  io2 read strobe.
- io_rdata  out  DATA_W  register read data (combinational).
- hal  out  1  bus-ownership / CPU-halt request.
- mem_addr  out  ADDR_W  data-memory address.
- mem_wdata  out  DATA_W  data-memory write data.
- mem_rdata  in  DATA_W  data-memory read data (combinational read).
- mem_read  out  1  data-memory read enable.
- mem_write  out  1  data-memory write enable (edge write).
- done_irq  out  1  level copy of STATUS.done.

Behaviour:
- Register map, selected by io_addr:
  - 0 = SRC, R/W.
  - 1 = DST, R/W.
  - 2 = LEN, R/W, low LEN_W bits; upper bits of io_wdata ignored, read back as 0.
  - 3 = CTRL/STATUS. On write: bit0 start, bit1 clear-done (W1C). On read: bit0 busy, bit1 done, other bits 0.
- io_rdata is the selected register when io_read=1, otherwise 0. While busy, reads return live values: current pointers and remaining count.
- Register writes while busy are ignored entirely, including start; clear-done is also ignored while busy.
- Reset, asynchronous: SRC=DST=LEN=0, busy=0, done=0, state=IDLE, buffer=0.
  - All outputs deassert immediately: hal, mem_read, mem_write=0; mem_addr, mem_wdata=0.
  - Reset in the middle of a transfer abandons it; memory already written stays written.
- FSM states: IDLE, RD, WR.
  - IDLE: a write of CTRL with bit0=1 at edge N clears done.
    - If LEN≠0: busy=1 and state=RD from edge N.
    - If LEN=0: no memory access; done=1 at edge N and state stays IDLE.
    - If bit0 and bit1 are written together, start wins and done ends the cycle at 0 (LEN≠0) or 1 (LEN=0).
  - RD: hal=1, mem_read=1, mem_addr=SRC. At the edge, buffer<=mem_rdata and state=WR.
  - WR: hal=1, mem_write=1, mem_addr=DST, mem_wdata=buffer. At the edge:
    - SRC+=1, DST+=1 (word-addressed), LEN-=1.
    - If the new LEN=0: state=IDLE, busy=0, done=1. Otherwise state=RD.
- Latency: hal is high for exactly 2*LEN cycles. done and busy=0 are visible on the cycle after the last WR.
- Pointer arithmetic: pointers wrap modulo 2^ADDR_W with no error flag. Overlapping regions copy strictly ascending, word by word; this is not memmove semantics.
- hal, mem_read and mem_write are registered-state decodes and glitch-free. mem_read and mem_write are never both 1.
- done stays set until a clear-done write or the next start. done_irq = done.

Decomposition:
- dma_pkg holds:
  - register offsets (REG_SRC=0, REG_DST=1, REG_LEN=2, REG_CTRL=3);
  - CTRL bit indices (START=0, CLR_DONE=1, BUSY=0, DONE=1);
  - the state enum {IDLE, RD, WR}.
- One sub-module, dma_regs: io decode, SRC/DST/LEN/done storage, and the read mux. It exposes load/increment/decrement controls to the FSM in dma_controller.

Test Plan:
- Basic copy: preload mem[0x10..0x13]=A,B,C,D; program SRC=0x10, DST=0x40, LEN=4, CTRL=1. Expect hal high for 8 cycles, mem[0x40..0x43]=A,B,C,D, then STATUS reads 0x2, done_irq=1, SRC=0x14, DST=0x44, LEN=0.
- Zero length: LEN=0, CTRL=1. Expect no mem_read/mem_write and hal never high; STATUS=0x2 on the next cycle.
- Busy lockout: during a LEN=3 copy, write SRC=0xFFFF and CTRL=1. Expect both ignored, the transfer completes with the original pointers, and mid-transfer reads show busy=1 and live LEN values.
- Done clear: after completion, write CTRL=0x2 → STATUS=0x0 and done_irq=0. Then CTRL=0x3 with LEN=0 → STATUS=0x2.
- Wrap-around: SRC=0xFFFFFFFF, DST=0x20, LEN=2. Expect reads from 0xFFFFFFFF then 0x0, writes to 0x20 and 0x21, final SRC=0x1.
- Reset mid-transfer: assert rst_n=0 during the second WR of a LEN=4 copy. Expect hal/mem_write low with no clock edge, all registers 0, only the first word (plus possibly the second) written, and the block restartable normally.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA block-copy engine: register map, CTRL/STATUS bits and FSM states.
package dma_pkg;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // Write-side CTRL bits
  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_DONE = 1;
  // Read-side STATUS bits
  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

endpackage

// File: rtl/dma_regs.sv
// DMA programming registers: io2 decode, SRC/DST/LEN/done storage and the io2 read mux.
// The FSM drives advance/done-set; this block reports start and length conditions back.
module dma_regs
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  input  logic              io_write,
  input  logic              io_read,
  output logic [DATA_W-1:0] io_rdata,
  input  logic              busy_i,
  input  logic              adv_i,
  input  logic              done_set_i,
  output logic              start_o,
  output logic              len_zero_o,
  output logic              last_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] src_o,
  output logic [ADDR_W-1:0] dst_o
);

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              done_q, done_d;
  logic              wr_en;

  // The whole register file is frozen while a transfer is running.
  assign wr_en      = io_write && !busy_i;
  assign start_o    = wr_en && (io_addr == REG_CTRL) && io_wdata[CTRL_START];
  assign len_zero_o = (len_q == '0);
  assign last_o     = (len_q == LEN_W'(1));
  assign done_o     = done_q;
  assign src_o      = src_q;
  assign dst_o      = dst_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned, which would infer a latch.
    src_d  = src_q;
    dst_d  = dst_q;
    len_d  = len_q;
    done_d = done_q;
    if (adv_i) begin
      src_d = src_q + ADDR_W'(1);
      dst_d = dst_q + ADDR_W'(1);
      len_d = len_q - LEN_W'(1);
    end
    if (done_set_i) done_d = 1'b1;
    if (wr_en) begin
      case (io_addr)
        REG_SRC: src_d = io_wdata[ADDR_W-1:0];
        REG_DST: dst_d = io_wdata[ADDR_W-1:0];
        REG_LEN: len_d = io_wdata[LEN_W-1:0];
        default: begin
          // Start overrides clear-done; a zero-length start completes at once.
          if (io_wdata[CTRL_START])         done_d = (len_q == '0);
          else if (io_wdata[CTRL_CLR_DONE]) done_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
    end else begin
      src_q  <= src_d;
      dst_q  <= dst_d;
      len_q  <= len_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    io_rdata = '0;
    if (io_read) begin
      case (io_addr)
        REG_SRC: io_rdata[ADDR_W-1:0] = src_q;
        REG_DST: io_rdata[ADDR_W-1:0] = dst_q;
        REG_LEN: io_rdata[LEN_W-1:0]  = len_q;
        default: begin
          io_rdata[STAT_BUSY] = busy_i;
          io_rdata[STAT_DONE] = done_q;
        end
      endcase
    end
  end

endmodule

// File: rtl/dma_controller.sv
// Memory-mapped block-copy engine on the io2 port: copies LEN words SRC->DST, one read and
// one write cycle per word, holding hal high while it owns the data-memory bus.
module dma_controller
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  input  logic              io_write,
  input  logic              io_read,
  output logic [DATA_W-1:0] io_rdata,
  output logic              hal,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              done_irq
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              busy, start, len_zero, last, adv, done_set;
  logic [ADDR_W-1:0] src, dst;

  assign busy = (state_q != IDLE);

  dma_regs #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LEN_W (LEN_W)
  ) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_write  (io_write),
    .io_read   (io_read),
    .io_rdata  (io_rdata),
    .busy_i    (busy),
    .adv_i     (adv),
    .done_set_i(done_set),
    .start_o   (start),
    .len_zero_o(len_zero),
    .last_o    (last),
    .done_o    (done_irq),
    .src_o     (src),
    .dst_o     (dst)
  );

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    adv      = 1'b0;
    done_set = 1'b0;
    case (state_q)
      IDLE: if (start && !len_zero) state_d = RD;
      RD: begin
        buf_d   = mem_rdata;
        state_d = WR;
      end
      WR: begin
        adv = 1'b1;
        if (last) begin
          done_set = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  // Bus outputs decode only the registered state, so they cannot glitch and drop with reset.
  assign hal       = busy;
  assign mem_read  = (state_q == RD);
  assign mem_write = (state_q == WR);
  assign mem_addr  = (state_q == RD) ? src : (state_q == WR) ? dst : '0;
  assign mem_wdata = (state_q == WR) ? buf_q : '0;

endmodule

// File: tb/tb_dma_controller.sv
// Self-checking bench for dma_controller: register-map vector table, directed corner sequences
// and randomized copies compared against a word-by-word copy model of the memory.
module tb_dma_controller;
  import dma_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic              clk;
  logic              rst_n;
  logic [1:0]        io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              io_write;
  logic              io_read;
  logic [DATA_W-1:0] io_rdata;
  logic              hal;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_read;
  logic              mem_write;
  logic              done_irq;

  dma_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_write (io_write),
    .io_read  (io_read),
    .io_rdata (io_rdata),
    .hal      (hal),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .done_irq (done_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 256-word data memory, aliased on the low address byte.
  logic [31:0] mem [256];
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;

  // Bus monitor, sampled mid-cycle.
  int          hal_cnt;
  int          both_cnt;
  logic [31:0] rd_log[$];
  logic [31:0] wr_log[$];
  always @(negedge clk) begin
    if (hal) hal_cnt++;
    if (mem_read) rd_log.push_back(mem_addr);
    if (mem_write) wr_log.push_back(mem_addr);
    if (mem_read && mem_write) both_cnt++;
  end

  int checks;
  int failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a falling edge; the write commits on the following rising edge.
  task automatic io_wr(input logic [1:0] a, input logic [31:0] d);
    io_addr  = a;
    io_wdata = d;
    io_write = 1'b1;
    @(negedge clk);
    io_write = 1'b0;
  endtask

  task automatic io_rd(input logic [1:0] a, output logic [31:0] d);
    io_addr = a;
    io_read = 1'b1;
    #1;
    d       = io_rdata;
    io_read = 1'b0;
  endtask

  task automatic expect_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    io_rd(a, d);
    check(name, d, exp);
  endtask

  task automatic clear_mon();
    hal_cnt = 0;
    rd_log.delete();
    wr_log.delete();
  endtask

  task automatic wait_done(input int budget, output int k);
    k = 0;
    while (!done_irq && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Full copy with model comparison: memory image, bus address sequences, latency, final registers.
  task automatic copy_and_check(input string name, input logic [31:0] src, input logic [31:0] dst,
                                input int len);
    logic [31:0] exp_mem [256];
    int          k;
    int          errs;
    exp_mem = mem;
    for (int i = 0; i < len; i++)
      exp_mem[8'(dst + 32'(i))] = exp_mem[8'(src + 32'(i))];
    io_wr(REG_CTRL, 32'h2);
    expect_reg({name, " pre-status"}, REG_CTRL, 32'h0);
    io_wr(REG_SRC, src);
    io_wr(REG_DST, dst);
    io_wr(REG_LEN, 32'(len));
    clear_mon();
    io_wr(REG_CTRL, 32'h1);
    wait_done(2 * len + 20, k);
    check({name, " latency"}, 32'(k), 32'(2 * len));
    check({name, " hal cycles"}, 32'(hal_cnt), 32'(2 * len));
    check({name, " reads"}, 32'(rd_log.size()), 32'(len));
    check({name, " writes"}, 32'(wr_log.size()), 32'(len));
    errs = 0;
    for (int i = 0; i < len && i < rd_log.size(); i++)
      if (rd_log[i] !== src + 32'(i)) errs++;
    for (int i = 0; i < len && i < wr_log.size(); i++)
      if (wr_log[i] !== dst + 32'(i)) errs++;
    check({name, " bus addrs"}, 32'(errs), 32'h0);
    @(negedge clk);
    errs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) errs++;
    check({name, " mem image"}, 32'(errs), 32'h0);
    check({name, " done_irq"}, {31'b0, done_irq}, 32'h1);
    expect_reg({name, " status"}, REG_CTRL, 32'h2);
    expect_reg({name, " src"}, REG_SRC, src + 32'(len));
    expect_reg({name, " dst"}, REG_DST, dst + 32'(len));
    expect_reg({name, " len"}, REG_LEN, 32'h0);
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reg_vec_t    vecs[7];
    logic [31:0] d;
    int          k;
    logic [31:0] s, t;
    int          l;

    checks   = 0;
    failures = 0;
    both_cnt = 0;
    clear_mon();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rst_n    = 1'b0;
    io_addr  = '0;
    io_wdata = '0;
    io_write = 1'b0;
    io_read  = 1'b0;

    // Reset state
    #12;
    check("rst hal", {31'b0, hal}, 32'h0);
    check("rst mem_read", {31'b0, mem_read}, 32'h0);
    check("rst mem_write", {31'b0, mem_write}, 32'h0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    check("rst done_irq", {31'b0, done_irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_reg("rst src", REG_SRC, 32'h0);
    expect_reg("rst dst", REG_DST, 32'h0);
    expect_reg("rst len", REG_LEN, 32'h0);
    expect_reg("rst status", REG_CTRL, 32'h0);

    // Register map vectors (idle)
    vecs[0] = '{REG_SRC,  32'h1234_5678, 32'h1234_5678};
    vecs[1] = '{REG_DST,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2] = '{REG_LEN,  32'hABCD_1234, 32'h0000_1234};
    vecs[3] = '{REG_LEN,  32'hFFFF_0000, 32'h0000_0000};
    vecs[4] = '{REG_CTRL, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[5] = '{REG_CTRL, 32'h0000_0002, 32'h0000_0000};
    vecs[6] = '{REG_SRC,  32'h8000_0001, 32'h8000_0001};
    for (int i = 0; i < 7; i++) begin
      io_wr(vecs[i].addr, vecs[i].wdata);
      expect_reg($sformatf("regvec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    io_addr = REG_SRC;
    #1;
    check("rdata gated", io_rdata, 32'h0);

    // Basic copy
    mem[8'h10] = 32'hAAAA_0001; mem[8'h11] = 32'hBBBB_0002;
    mem[8'h12] = 32'hCCCC_0003; mem[8'h13] = 32'hDDDD_0004;
    copy_and_check("basic", 32'h10, 32'h40, 4);
    check("basic w0", mem[8'h40], 32'hAAAA_0001);
    check("basic w3", mem[8'h43], 32'hDDDD_0004);

    // Done clear, then start+clear together with LEN=0
    io_wr(REG_CTRL, 32'h2);
    expect_reg("clr status", REG_CTRL, 32'h0);
    check("clr done_irq", {31'b0, done_irq}, 32'h0);
    clear_mon();
    io_wr(REG_CTRL, 32'h3);
    expect_reg("start+clr len0 status", REG_CTRL, 32'h2);
    check("start+clr len0 hal", 32'(hal_cnt), 32'h0);

    // Zero length
    copy_and_check("zero", 32'h30, 32'h50, 0);

    // Busy lockout during a LEN=3 copy
    io_wr(REG_CTRL, 32'h2);
    io_wr(REG_SRC, 32'h70);
    io_wr(REG_DST, 32'h90);
    io_wr(REG_LEN, 32'h3);
    clear_mon();
    io_wr(REG_CTRL, 32'h1);
    expect_reg("busy status", REG_CTRL, 32'h1);
    expect_reg("busy len0", REG_LEN, 32'h3);
    io_wr(REG_SRC, 32'hFFFF);
    io_wr(REG_CTRL, 32'h1);
    expect_reg("busy len1", REG_LEN, 32'h2);
    expect_reg("busy src live", REG_SRC, 32'h71);
    wait_done(40, k);
    @(negedge clk);
    check("busy hal cycles", 32'(hal_cnt), 32'h6);
    check("busy done", {31'b0, done_irq}, 32'h1);
    expect_reg("busy final src", REG_SRC, 32'h73);
    expect_reg("busy final dst", REG_DST, 32'h93);
    check("busy mem", mem[8'h92], mem[8'h72]);

    // Wrap-around
    mem[8'hFF] = 32'h0BAD_CAFE;
    mem[8'h00] = 32'h0000_F00D;
    copy_and_check("wrap", 32'hFFFF_FFFF, 32'h20, 2);
    check("wrap w0", mem[8'h20], 32'h0BAD_CAFE);
    check("wrap w1", mem[8'h21], 32'h0000_F00D);

    // Reset in the middle of the second write of a LEN=4 copy
    for (int i = 0; i < 4; i++) begin
      mem[8'h50 + 8'(i)] = 32'h5000_0000 + 32'(i);
      mem[8'h60 + 8'(i)] = 32'h0;
    end
    io_wr(REG_SRC, 32'h50);
    io_wr(REG_DST, 32'h60);
    io_wr(REG_LEN, 32'h4);
    io_wr(REG_CTRL, 32'h1);
    repeat (3) @(negedge clk);
    check("mid wr1 active", {31'b0, mem_write}, 32'h1);
    check("mid wr1 addr", mem_addr, 32'h61);
    #1 rst_n = 1'b0;
    #1;
    check("mid hal", {31'b0, hal}, 32'h0);
    check("mid mem_write", {31'b0, mem_write}, 32'h0);
    check("mid mem_addr", mem_addr, 32'h0);
    expect_reg("mid src", REG_SRC, 32'h0);
    expect_reg("mid len", REG_LEN, 32'h0);
    expect_reg("mid status", REG_CTRL, 32'h0);
    check("mid word0", mem[8'h60], 32'h5000_0000);
    check("mid word2", mem[8'h62], 32'h0);
    check("mid word3", mem[8'h63], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    copy_and_check("restart", 32'h50, 32'h60, 4);

    // Randomized copies, overlap allowed
    for (int n = 0; n < 20; n++) begin
      s = 32'($urandom_range(0, 127));
      t = 32'($urandom_range(0, 127));
      l = int'($urandom_range(0, 12));
      copy_and_check($sformatf("rand%0d", n), s, t, l);
    end

    check("rd/wr exclusive", 32'(both_cnt), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
